// File: rtl/adapter_req_arbiter.sv
// Round-robin arbiter that funnels several requesting ports onto one AXI
// adapter request channel. It tags each request with the winning port index
// as the transaction ID, tracks outstanding transactions per port, and
// routes adapter responses back to the owning port.
module adapter_req_arbiter #(
  parameter int NUM_PORTS    = 3,
  parameter int AXI_ID_WIDTH = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int MAX_OUT      = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_PORTS-1:0]                   req_port_i,
  input  logic [NUM_PORTS-1:0][63:0]             addr_port_i,
  input  logic [NUM_PORTS-1:0]                   we_port_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_port_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_port_i,
  input  logic [NUM_PORTS-1:0][1:0]              size_port_i,
  output logic [NUM_PORTS-1:0]                   gnt_port_o,
  output logic [NUM_PORTS-1:0]                   valid_port_o,
  output logic [DATA_WIDTH-1:0]                  rdata_port_o,
  output logic                                   req_o,
  output logic [63:0]                            addr_o,
  output logic                                   we_o,
  output logic [DATA_WIDTH-1:0]                  wdata_o,
  output logic [DATA_WIDTH/8-1:0]                be_o,
  output logic [1:0]                             size_o,
  output logic [AXI_ID_WIDTH-1:0]                id_o,
  input  logic                                   gnt_i,
  input  logic                                   valid_i,
  input  logic [DATA_WIDTH-1:0]                  rdata_i,
  input  logic [AXI_ID_WIDTH-1:0]                id_i,
  output logic                                   err_o
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [1:0]                  rr_q;
  logic [1:0]                  sel;
  logic [1:0]                  pick;
  logic                        pick_valid;
  logic [NUM_PORTS-1:0]        eligible;
  logic [NUM_PORTS-1:0][1:0]   cnt;
  logic [NUM_PORTS-1:0]        resp_dec;
  logic                        resp_hit;
  logic [1:0]                  resp_port;
  logic                        id_unused;

  // Only the two LSBs of the response ID carry the port index.
  assign id_unused = ^(id_i >> 2);
  assign resp_port = id_i[1:0];
  assign id_o      = AXI_ID_WIDTH'(sel);

  // A port may compete only while it has room for another outstanding transaction.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = req_port_i[p] && (cnt[p] < 2'(MAX_OUT));
    end
  end

  // Round-robin pick: the eligible port with the smallest distance from rr_q wins.
  always_comb begin
    int  best_off;
    int  off;
    logic take;
    best_off   = NUM_PORTS;
    off        = 0;
    take       = 1'b0;
    pick       = 2'd0;
    pick_valid = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      off        = (p + NUM_PORTS - int'(rr_q)) % NUM_PORTS;
      take       = eligible[p] && (off < best_off);
      best_off   = take ? off : best_off;
      pick       = take ? 2'(p) : pick;
      pick_valid = pick_valid | take;
    end
  end

  // Next-state logic and the combinational per-port grant.
  always_comb begin
    state_next = state;
    gnt_port_o = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = WAIT_GNT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_GNT: begin
        if (gnt_i) begin
          state_next = IDLE;
          gnt_port_o = NUM_PORTS'(1) << sel;
        end else begin
          state_next = WAIT_GNT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winner's request fields and hold them until the adapter grants.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_o  <= 1'b0;
      sel    <= 2'd0;
      rr_q   <= 2'd0;
      addr_o <= 64'd0;
      we_o   <= 1'b0;
      wdata_o <= '0;
      be_o   <= '0;
      size_o <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            req_o   <= 1'b1;
            sel     <= pick;
            addr_o  <= addr_port_i[pick];
            we_o    <= we_port_i[pick];
            wdata_o <= wdata_port_i[pick];
            be_o    <= be_port_i[pick];
            size_o  <= size_port_i[pick];
          end
        end
        WAIT_GNT: begin
          if (gnt_i) begin
            req_o <= 1'b0;
            rr_q  <= (sel == 2'(NUM_PORTS - 1)) ? 2'd0 : sel + 2'd1;
          end
        end
        default: begin
          req_o <= 1'b0;
        end
      endcase
    end
  end

  // A response is accepted only for an existing port with an outstanding transaction.
  always_comb begin
    resp_dec = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_dec[p] = valid_i && (resp_port == 2'(p)) && (cnt[p] != 2'd0);
    end
    resp_hit = |resp_dec;
  end

  // Outstanding counters: grant adds one, accepted response removes one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        case ({gnt_port_o[p], resp_dec[p]})
          2'b10:   cnt[p] <= cnt[p] + 2'd1;
          2'b01:   cnt[p] <= cnt[p] - 2'd1;
          default: cnt[p] <= cnt[p];
        endcase
      end
    end
  end

  // Register the routed response; unroutable responses latch the sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_port_o <= '0;
      rdata_port_o <= '0;
      err_o        <= 1'b0;
    end else begin
      valid_port_o <= resp_dec;
      if (resp_hit) begin
        rdata_port_o <= rdata_i;
      end
      err_o <= err_o | (valid_i & ~resp_hit);
    end
  end

endmodule

// File: doc/adapter_req_arbiter.md
ADAPTER_REQ_ARBITER -- requirements
Module: adapter_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of requesting ports (2..4).
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 4, width of the adapter transaction ID; must be >= 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, width of the write and read data words.
REQ-004 SHALL have parameter MAX_OUT, default 2, maximum outstanding transactions per port (1..3).
REQ-005 SHALL provide ports, in this order:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_port_i  in  NUM_PORTS  per-port request.
- addr_port_i  in  NUM_PORTS x 64  per-port address.
- we_port_i  in  NUM_PORTS  per-port write enable.
- wdata_port_i  in  NUM_PORTS x DATA_WIDTH  per-port write data.
- be_port_i  in  NUM_PORTS x DATA_WIDTH/8  per-port byte enables.
- size_port_i  in  NUM_PORTS x 2  per-port access size.
- gnt_port_o  out  NUM_PORTS  per-port grant.
- valid_port_o  out  NUM_PORTS  per-port response valid.
- rdata_port_o  out  DATA_WIDTH  response data, shared by all ports.
- req_o, addr_o, we_o, wdata_o, be_o, size_o  out  1/64/1/DATA_WIDTH/DATA_WIDTH/8/2  request to the AXI adapter.
- id_o  out  AXI_ID_WIDTH  transaction ID to the adapter.
- gnt_i  in  1  adapter grant.
- valid_i  in  1  adapter response valid.
- rdata_i  in  DATA_WIDTH  adapter response data.
- id_i  in  AXI_ID_WIDTH  adapter response ID.
- err_o  out  1  sticky protocol error.

Function
REQ-006 SHALL implement FSM states IDLE and WAIT_GNT.
REQ-007 IDLE: when at least one eligible port requests, SHALL select one port by round-robin, register that port's request fields, and enter WAIT_GNT on the next edge.
REQ-008 A port SHALL be eligible only when req_port_i is high and its outstanding count is < MAX_OUT.
REQ-009 Round-robin SHALL start the search at pointer rr_q and proceed in ascending index order with wrap-around; rr_q resets to 0.
REQ-010 WAIT_GNT: req_o SHALL be 1 and all request outputs SHALL hold their registered values, stable until gnt_i.
REQ-011 On gnt_i in WAIT_GNT:
- gnt_port_o[sel] SHALL be 1 in that same cycle (combinational from gnt_i).
- rr_q SHALL become (sel+1) mod NUM_PORTS.
- the FSM SHALL return to IDLE.
REQ-012 Back-to-back operation: at most one grant per 2 cycles; from request to req_o the latency is 1 cycle.
REQ-013 id_o SHALL be {zeros, sel} with sel in the 2 LSBs.
REQ-014 Each port SHALL have a 2-bit outstanding counter:
- +1 on its grant.
- -1 on a response routed to it.
- unchanged when both events occur in the same cycle.
REQ-015 Responses: when valid_i is high, the port p = id_i[1:0] SHALL receive valid_port_o[p] = 1 one cycle later, with rdata_port_o = the registered rdata_i.
REQ-016 A response to p >= NUM_PORTS, or to a port with a zero count, SHALL be dropped (no valid_port_o) and SHALL set err_o.
REQ-017 err_o SHALL be sticky until reset.
REQ-018 A requester deasserting req_port_i while in WAIT_GNT SHALL NOT affect the held request.
REQ-019 At most one valid_port_o bit SHALL be high in any cycle.

Reset
REQ-020 While rst_ni is low, the following SHALL be 0: req_o, gnt_port_o, valid_port_o, err_o, all counters, rr_q, and the registered outputs. The FSM SHALL be in IDLE.
REQ-021 Reset asserted mid-transaction SHALL abandon the held request and clear the counters; post-reset responses to old IDs set err_o.
REQ-022 After rst_ni rises, the first req_o SHALL occur no earlier than 1 cycle after the first request sampled.

Verification
REQ-023 Ports 0, 1 and 2 request simultaneously with gnt_i tied high -> grants in order 0, 1, 2, 0..., one every 2 cycles; id_o = 0, 1, 2.
REQ-024 Port 1 requests addr 0x80001000, we=1, and gnt_i is delayed 5 cycles -> req_o and addr_o stay stable for 5 cycles; gnt_port_o[1] pulses in the gnt_i cycle.
REQ-025 Port 0 granted twice with no response (MAX_OUT=2) -> port 0 is not eligible; port 2 is served. A response with id 0 and rdata 0xDEADBEEF -> valid_port_o[0] 1 cycle later with that data; port 0 becomes eligible again.
REQ-026 valid_i with id_i=3 and NUM_PORTS=3 -> no valid_port_o; err_o=1 and stays 1.
REQ-027 Grant and response for port 2 in the same cycle -> counter unchanged; valid_port_o[2] 1 cycle later.
REQ-028 rst_ni pulsed low during WAIT_GNT -> req_o drops immediately and counters are 0; rr_q=0 afterwards.
